cbd_poly_sampler: RTL and testbench

CBD_POLY_SAMPLER -- requirements
Module: cbd_poly_sampler

---
 rtl/types_kem.sv | 10 +
 rtl/cbd_coef_calc.sv | 15 +
 rtl/cbd_poly_sampler.sv | 73 +++++++
 tb/tb_cbd_poly_sampler.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/types_kem.sv
// types_kem: shared ML-KEM constants for the CBD polynomial sampler.
package types_kem;
  localparam int KEM_Q = 3329;
  localparam int KEM_N = 256;
  localparam int WORDS_ETA2 = 16;
  localparam int WORDS_ETA3 = 24;
  function automatic logic [4:0] eta_words(input logic eta3);
    return eta3 ? 5'(WORDS_ETA3) : 5'(WORDS_ETA2);
  endfunction
endpackage

// File: rtl/cbd_coef_calc.sv
// cbd_coef_calc: centered binomial coefficient (a - b mod Q) from the buffer head.
module cbd_coef_calc import types_kem::*; #(
  parameter int Q = KEM_Q
) (
  input  logic        eta3,
  input  logic [5:0]  head,
  output logic [11:0] coef
);
  logic [1:0] a, b;
  always_comb begin
    a = 2'(head[0]) + 2'(head[1]) + (eta3 ? 2'(head[2]) : 2'd0);
    b = eta3 ? 2'(head[3]) + 2'(head[4]) + 2'(head[5]) : 2'(head[2]) + 2'(head[3]);
    coef = a >= b ? 12'(a - b) : 12'(Q) + 12'(a) - 12'(b);
  end
endmodule

// File: rtl/cbd_poly_sampler.sv
// cbd_poly_sampler: packs 64-bit PRF words into a 128-bit bit buffer and
// streams N centered-binomial coefficients mod Q with valid/ready handshakes.
module cbd_poly_sampler import types_kem::*; #(
  parameter int Q = KEM_Q,
  parameter int N = KEM_N
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        run_i,
  input  logic        eta_i,
  input  logic [63:0] din_i,
  input  logic        din_valid_i,
  output logic        din_ready_o,
  output logic [11:0] coef_o,
  output logic [7:0]  coef_idx_o,
  output logic        coef_valid_o,
  input  logic        coef_ready_i,
  output logic        busy_o,
  output logic        done_o
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic [127:0] buffer, buffer_nx;
  logic [7:0] count, count_nx, take, base, idx;
  logic [4:0] words;
  logic eta3, din_fire, coef_fire, last;
  always_comb begin
    take = eta3 ? 8'd6 : 8'd4;
    din_ready_o = state == RUN && count <= 8'd64 && words < eta_words(eta3);
    coef_valid_o = state == RUN && count >= take;
    din_fire = din_valid_i && din_ready_o;
    coef_fire = coef_valid_o && coef_ready_i;
    last = coef_fire && idx == 8'(N - 1);
    // a word arriving with a consumed coefficient lands just above the surviving bits
    base = coef_fire ? count - take : count;
    buffer_nx = (coef_fire ? buffer >> take : buffer) | (din_fire ? {64'd0, din_i} << base : 128'd0);
    count_nx = base + (din_fire ? 8'd64 : 8'd0);
    busy_o = state != IDLE;
    done_o = state == DONE;
    coef_idx_o = idx;
  end
  cbd_coef_calc #(.Q(Q)) u_calc (
    .eta3 (eta3),
    .head (buffer[5:0]),
    .coef (coef_o)
  );
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state <= IDLE;
      buffer <= '0;
      count <= '0;
      words <= '0;
      idx <= '0;
      eta3 <= 1'b0;
    end else if (state == IDLE) begin
      if (run_i) begin
        state <= RUN;
        buffer <= '0;
        count <= '0;
        words <= '0;
        idx <= '0;
        eta3 <= eta_i;
      end
    end else if (state == RUN) begin
      buffer <= buffer_nx;
      count <= count_nx;
      words <= words + 5'(din_fire);
      if (coef_fire && !last) idx <= idx + 8'd1;
      if (last) state <= DONE;
    end else begin
      state <= IDLE;
    end
endmodule

// File: tb/tb_cbd_poly_sampler.sv
// tb_cbd_poly_sampler: directed and randomized runs checked against a bitstream CBD model.
module tb_cbd_poly_sampler;
  logic clk_i = 1'b0;
  logic rst_n_i, run_i, eta_i, din_valid_i, din_ready_o, coef_valid_o, coef_ready_i, busy_o, done_o;
  logic [63:0] din_i;
  logic [11:0] coef_o;
  logic [7:0] coef_idx_o;
  int tests = 0, fails = 0;
  logic [63:0] words [24];
  logic [11:0] exp_c [256];
  logic [11:0] got [256];

  cbd_poly_sampler dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .run_i        (run_i),
    .eta_i        (eta_i),
    .din_i        (din_i),
    .din_valid_i  (din_valid_i),
    .din_ready_o  (din_ready_o),
    .coef_o       (coef_o),
    .coef_idx_o   (coef_idx_o),
    .coef_valid_o (coef_valid_o),
    .coef_ready_i (coef_ready_i),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int bit_at(int p);
    return int'(words[p / 64][p % 64]);
  endfunction

  // reference: read the little-endian bitstream directly, 2*eta bits per coefficient
  function automatic void build_exp(bit e);
    int n = e ? 3 : 2;
    for (int i = 0; i < 256; i++) begin
      int a = 0;
      int b = 0;
      for (int j = 0; j < n; j++) begin
        a += bit_at(2 * n * i + j);
        b += bit_at(2 * n * i + n + j);
      end
      exp_c[i] = 12'((a - b + 3329) % 3329);
    end
  endfunction

  task automatic check_zero_outputs(input string tag);
    chk({tag, " din_ready"}, din_ready_o, 0);
    chk({tag, " coef_valid"}, coef_valid_o, 0);
    chk({tag, " busy"}, busy_o, 0);
    chk({tag, " done"}, done_o, 0);
    chk({tag, " coef"}, coef_o, 0);
    chk({tag, " coef_idx"}, coef_idx_o, 0);
  endtask

  task automatic run_case(input string tag, input bit e, input int vp, input int rp, input int abort_at);
    int nw = e ? 24 : 16;
    int wi = 0, ci = 0, cyc = 0, dones = 0, fw = -1;
    bit fin = 0, aborted = 0, stall = 0;
    logic [11:0] pc;
    logic [7:0] pi;
    build_exp(e);
    @(negedge clk_i);
    run_i = 1'b1;
    eta_i = e;
    din_valid_i = 1'b0;
    coef_ready_i = 1'b0;
    @(negedge clk_i);
    chk({tag, " busy_after_run"}, busy_o, 1);
    chk({tag, " no_coef_before_data"}, coef_valid_o, 0);
    chk({tag, " ready_at_start"}, din_ready_o, 1);
    while (!fin && cyc < 6000) begin
      din_valid_i = $urandom_range(99) < vp;
      din_i = wi < nw ? words[wi] : {$urandom, $urandom};
      coef_ready_i = $urandom_range(99) < rp;
      eta_i = 1'($urandom);
      run_i = $urandom_range(7) == 0;
      #1;
      if (stall) begin
        chk({tag, " stall_valid"}, coef_valid_o, 1);
        chk({tag, " stall_coef"}, coef_o, pc);
        chk({tag, " stall_idx"}, coef_idx_o, pi);
      end
      if (fw >= 0 && cyc == fw + 1) chk({tag, " first_valid"}, coef_valid_o, 1);
      stall = coef_valid_o && !coef_ready_i;
      pc = coef_o;
      pi = coef_idx_o;
      if (done_o) begin
        dones++;
        fin = 1;
      end
      if (din_valid_i && din_ready_o) begin
        if (fw < 0) fw = cyc;
        wi++;
      end
      if (coef_valid_o && coef_ready_i) begin
        chk($sformatf("%s idx_in_range", tag), ci < 256, 1);
        chk($sformatf("%s idx[%0d]", tag, ci), coef_idx_o, 64'(ci));
        if (ci < 256) begin
          chk($sformatf("%s coef[%0d]", tag, ci), coef_o, exp_c[ci]);
          got[ci] = coef_o;
        end
        ci++;
        if (ci == abort_at) begin
          @(posedge clk_i);
          #2;
          rst_n_i = 1'b0;
          #1;
          check_zero_outputs({tag, " abort"});
          aborted = 1;
          fin = 1;
        end
      end
      @(negedge clk_i);
      cyc++;
    end
    run_i = 1'b0;
    din_valid_i = 1'b0;
    coef_ready_i = 1'b0;
    chk({tag, " finished_in_budget"}, fin, 1);
    if (aborted) begin
      chk({tag, " abort_no_done"}, dones, 0);
      check_zero_outputs({tag, " held_reset"});
      @(negedge clk_i);
      rst_n_i = 1'b1;
    end else begin
      chk({tag, " coef_count"}, ci, 256);
      chk({tag, " word_handshakes"}, wi, nw);
      chk({tag, " done_pulses"}, dones, 1);
      chk({tag, " idle_busy"}, busy_o, 0);
      chk({tag, " done_one_cycle"}, done_o, 0);
      if (vp == 100 && rp == 100) chk({tag, " latency_ok"}, cyc <= nw + 258, 1);
    end
  endtask

  initial begin
    rst_n_i = 1'b1;
    run_i = 1'b0;
    eta_i = 1'b0;
    din_i = '0;
    din_valid_i = 1'b0;
    coef_ready_i = 1'b0;
    #1 rst_n_i = 1'b0;
    #1 check_zero_outputs("reset");
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
    @(negedge clk_i);
    chk("idle busy", busy_o, 0);
    chk("idle din_ready", din_ready_o, 0);

    for (int i = 0; i < 24; i++) words[i] = 64'h3333_3333_3333_3333;
    run_case("eta2_3333", 1'b0, 100, 100, -1);
    chk("eta2_3333 first", got[0], 2);
    chk("eta2_3333 last", got[255], 2);

    for (int i = 0; i < 24; i++) words[i] = 64'hCCCC_CCCC_CCCC_CCCC;
    run_case("eta2_cccc", 1'b0, 100, 100, -1);
    chk("eta2_cccc first", got[0], 3327);
    chk("eta2_cccc last", got[255], 3327);

    for (int i = 0; i < 24; i++) words[i] = '1;
    run_case("eta3_ones", 1'b1, 100, 100, -1);
    chk("eta3_ones first", got[0], 0);
    chk("eta3_ones last", got[255], 0);

    for (int p = 0; p < 1536; p++) words[p / 64][p % 64] = (p % 6) < 3;
    run_case("eta3_000111", 1'b1, 100, 100, -1);
    chk("eta3_000111 idx10", got[10], 3);
    chk("eta3_000111 idx21", got[21], 3);
    chk("eta3_000111 idx42", got[42], 3);

    for (int i = 0; i < 24; i++) words[i] = {$urandom, $urandom};
    run_case("rand_eta2", 1'b0, 60, 50, -1);
    for (int i = 0; i < 24; i++) words[i] = {$urandom, $urandom};
    run_case("rand_eta3", 1'b1, 45, 70, -1);
    for (int i = 0; i < 24; i++) words[i] = {$urandom, $urandom};
    run_case("abort", 1'b1, 100, 100, 101);
    for (int i = 0; i < 24; i++) words[i] = {$urandom, $urandom};
    run_case("after_abort", 1'($urandom), 70, 60, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
